// File: rtl/cache_control_nway.sv
// WAYS-way write-back/write-allocate cache control FSM with per-set tree-PLRU; hit in 1 cycle, miss 1 + [wb] + fill + 1.
// Stalls the CPU by withholding mem_resp; pmem requests held until pmem_resp. `CACHE_PERF_CNT_EN adds hit/miss/wb counters.
module cache_control_nway #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SETS  = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [$clog2(SETS)-1:0]  set_idx,
  input  logic [WAYS-1:0]          way_hit,
  input  logic [WAYS-1:0]          way_valid,
  input  logic [WAYS-1:0]          way_dirty,
  input  logic                     pmem_resp,
  output logic                     mem_resp,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic                     pmem_addr_sel,
  output logic [$clog2(WAYS)-1:0]  victim_way,
  output logic [WAYS-1:0]          data_we,
  output logic [WAYS-1:0]          tag_we,
  output logic                     data_sel,
  output logic [WAYS-1:0]          valid_set,
  output logic [WAYS-1:0]          dirty_set,
  output logic [WAYS-1:0]          dirty_clr,
  output logic                     busy
`ifdef CACHE_PERF_CNT_EN
  ,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic [CNT_W-1:0]         wb_cnt
`endif
);

  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned NODE_W = WAY_W + 1;
  localparam int unsigned TREE_W = WAYS - 1;

  if (WAYS < 2 || WAYS > 16 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
    $error("cache_control_nway: WAYS must be a power of 2 in 2..16");
  end
  if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
    $error("cache_control_nway: SETS must be a power of 2, at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cache_control_nway: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic [TREE_W-1:0]   plru_q [SETS];

  logic                req;
  logic                hit_any;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    pick_way;
  logic                plru_upd;
  logic [WAY_W-1:0]    plru_way;

  // Walk the heap-ordered tree from the root; a 0 bit steers toward the lower child.
  function automatic logic [WAY_W-1:0] plru_pick(input logic [TREE_W-1:0] tree);
    logic [2*WAYS-1:0] bits;
    logic [NODE_W-1:0] node;
    bits = '0;
    bits[TREE_W-1:0] = tree;
    node = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      node = (node << 1) + NODE_W'(1) + NODE_W'(bits[node]);
    end
    return WAY_W'(node - NODE_W'(TREE_W));
  endfunction

  // Point every node on the path of the accessed way away from it.
  function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] tree,
                                                   input logic [WAY_W-1:0]  way);
    logic [2*WAYS-1:0] bits;
    logic [NODE_W-1:0] node;
    logic [WAY_W-1:0]  path;
    logic              dir;
    bits = '0;
    bits[TREE_W-1:0] = tree;
    node = '0;
    path = way;
    for (int l = 0; l < int'(WAY_W); l++) begin
      dir        = path[WAY_W-1];
      path       = path << 1;
      bits[node] = ~dir;
      node       = (node << 1) + NODE_W'(1) + NODE_W'(dir);
    end
    return bits[TREE_W-1:0];
  endfunction

  function automatic logic [WAY_W-1:0] lowest_set(input logic [WAYS-1:0] vec);
    logic [WAYS-1:0]  v;
    logic [WAY_W-1:0] idx;
    logic             found;
    v     = vec;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (v[0] && !found) begin
        idx   = WAY_W'(i);
        found = 1'b1;
      end
      v = v >> 1;
    end
    return idx;
  endfunction

  function automatic logic [WAYS-1:0] onehot(input logic [WAY_W-1:0] idx);
    logic [WAYS-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return one << idx;
  endfunction

  assign req      = mem_read | mem_write;
  assign hit_any  = |way_hit;
  assign hit_way  = lowest_set(way_hit);
  assign pick_way = (&way_valid) ? plru_pick(plru_q[set_idx]) : lowest_set(~way_valid);

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    plru_upd      = 1'b0;
    plru_way      = '0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    victim_way    = '0;
    data_we       = '0;
    tag_we        = '0;
    data_sel      = 1'b0;
    valid_set     = '0;
    dirty_set     = '0;
    dirty_clr     = '0;
    busy          = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit_any) begin
            mem_resp = 1'b1;
            plru_upd = 1'b1;
            plru_way = hit_way;
            if (mem_write) begin
              data_we   = onehot(hit_way);
              dirty_set = onehot(hit_way);
            end
          end else begin
            victim_d = pick_way;
            state_d  = (way_valid[pick_way] && way_dirty[pick_way]) ? WB : FILL;
          end
        end
      end
      WB: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        victim_way    = victim_q;
        if (pmem_resp) begin
          dirty_clr = onehot(victim_q);
          state_d   = FILL;
        end
      end
      FILL: begin
        pmem_read  = 1'b1;
        victim_way = victim_q;
        if (pmem_resp) begin
          data_we   = onehot(victim_q);
          tag_we    = onehot(victim_q);
          valid_set = onehot(victim_q);
          dirty_clr = onehot(victim_q);
          data_sel  = 1'b1;
          plru_upd  = 1'b1;
          plru_way  = victim_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset wins over whatever the FSM was doing, including the state it is leaving.
    if (!rst_n) begin
      state_d       = IDLE;
      victim_d      = '0;
      plru_upd      = 1'b0;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      victim_way    = '0;
      data_we       = '0;
      tag_we        = '0;
      data_sel      = 1'b0;
      valid_set     = '0;
      dirty_set     = '0;
      dirty_clr     = '0;
      busy          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        plru_q[s] <= '0;
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (plru_upd) begin
        plru_q[set_idx] <= plru_touch(plru_q[set_idx], plru_way);
      end
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic hit_evt, miss_evt, wb_evt;

  assign hit_evt  = (state_q == IDLE) && req && hit_any;
  assign miss_evt = (state_q == IDLE) && req && !hit_any;
  assign wb_evt   = (state_q == WB) && pmem_resp;

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_evt && !(&hit_cnt)) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
      if (miss_evt && !(&miss_cnt)) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
      if (wb_evt && !(&wb_cnt)) begin
        wb_cnt <= wb_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench for cache_control_nway (WAYS=4, SETS=8): hits, writeback miss, PLRU order, invalid-way victim, reset mid-fill.
module tb_cache_control_nway;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  set_idx;
  logic [3:0]  way_hit, way_valid, way_dirty;
  logic        pmem_resp;
  logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel;
  logic [1:0]  victim_way;
  logic [3:0]  data_we, tag_we, valid_set, dirty_set, dirty_clr;
  logic        data_sel, busy;
`ifdef CACHE_PERF_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_control_nway #(.WAYS(4), .SETS(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .set_idx(set_idx),
    .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
    .pmem_resp(pmem_resp), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel),
    .victim_way(victim_way), .data_we(data_we), .tag_we(tag_we),
    .data_sel(data_sel), .valid_set(valid_set), .dirty_set(dirty_set),
    .dirty_clr(dirty_clr), .busy(busy)
`ifdef CACHE_PERF_CNT_EN
    , .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  logic [27:0] outs;
  assign outs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel, busy,
                 victim_way, data_we, tag_we, valid_set, dirty_set, dirty_clr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; set_idx = '0;
    way_hit = '0; way_valid = '0; way_dirty = '0; pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("rst_outs", 32'(outs), 'h0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("idle_outs", 32'(outs), 'h0);

    // read hit, way 1
    @(negedge clk); set_idx = 3'd0; mem_read = 1'b1; way_hit = 4'b0010; way_valid = 4'b1111;
    #1;
    chk("rd_hit_resp", 32'(mem_resp), 'h1);
    chk("rd_hit_pmem", 32'({pmem_read, pmem_write}), 'h0);
    chk("rd_hit_busy", 32'(busy), 'h0);
    chk("rd_hit_we", 32'(data_we), 'h0);

    // write hit, way 3
    @(negedge clk); mem_read = 1'b0; mem_write = 1'b1; way_hit = 4'b1000;
    #1;
    chk("wr_hit_we", 32'(data_we), 'h8);
    chk("wr_hit_dirty", 32'(dirty_set), 'h8);
    chk("wr_hit_sel", 32'(data_sel), 'h0);
    chk("wr_hit_resp", 32'(mem_resp), 'h1);
    chk("wr_hit_tag", 32'(tag_we), 'h0);

    // multiple hits: lowest index wins
    @(negedge clk); way_hit = 4'b0110;
    #1 chk("multi_hit_we", 32'(data_we), 'h2);

    // read miss, set 1, all valid, victim 0 dirty -> writeback
    @(negedge clk); mem_write = 1'b0; mem_read = 1'b1; set_idx = 3'd1;
    way_hit = 4'b0000; way_valid = 4'b1111; way_dirty = 4'b0001;
    #1 chk("miss_cycle_outs", 32'(outs), 'h0);
    @(negedge clk);
    #1;
    chk("wb_pmem_write", 32'(pmem_write), 'h1);
    chk("wb_addr_sel", 32'(pmem_addr_sel), 'h1);
    chk("wb_victim", 32'(victim_way), 'h0);
    chk("wb_busy", 32'(busy), 'h1);
    chk("wb_no_read", 32'(pmem_read), 'h0);
    repeat (4) @(negedge clk);
    #1;
    chk("wb_hold_write", 32'(pmem_write), 'h1);
    chk("wb_hold_dclr", 32'(dirty_clr), 'h0);
    @(negedge clk); pmem_resp = 1'b1;
    #1;
    chk("wb_done_dclr", 32'(dirty_clr), 'h1);
    chk("wb_done_we", 32'(data_we), 'h0);
    @(negedge clk); pmem_resp = 1'b0;
    #1;
    chk("fill_read", 32'(pmem_read), 'h1);
    chk("fill_no_write", 32'(pmem_write), 'h0);
    chk("fill_addr_sel", 32'(pmem_addr_sel), 'h0);
    @(negedge clk); pmem_resp = 1'b1;
    #1;
    chk("fill_data_we", 32'(data_we), 'h1);
    chk("fill_tag_we", 32'(tag_we), 'h1);
    chk("fill_valid_set", 32'(valid_set), 'h1);
    chk("fill_dirty_clr", 32'(dirty_clr), 'h1);
    chk("fill_data_sel", 32'(data_sel), 'h1);
    chk("fill_no_resp", 32'(mem_resp), 'h0);
    @(negedge clk); pmem_resp = 1'b0; way_hit = 4'b0001; way_dirty = 4'b0000;
    #1;
    chk("refill_hit_resp", 32'(mem_resp), 'h1);
    chk("refill_hit_busy", 32'(busy), 'h0);

    // PLRU on set 2: touch way 0 -> victim 2; fill way 2 -> victim 1
    @(negedge clk); set_idx = 3'd2; way_hit = 4'b0001;
    #1 chk("s2_hit0_resp", 32'(mem_resp), 'h1);
    @(negedge clk); way_hit = 4'b0000;
    @(negedge clk);
    #1;
    chk("plru_victim2", 32'(victim_way), 'h2);
    chk("s2_clean_fill", 32'({pmem_write, pmem_read}), 'h1);
    @(negedge clk); pmem_resp = 1'b1;
    #1 chk("s2_fill2_we", 32'(data_we), 'h4);
    @(negedge clk); pmem_resp = 1'b0; way_hit = 4'b0100;
    #1 chk("s2_rehit2_resp", 32'(mem_resp), 'h1);
    @(negedge clk); way_hit = 4'b0000;
    @(negedge clk);
    #1 chk("plru_victim1", 32'(victim_way), 'h1);
    @(negedge clk); pmem_resp = 1'b1;
    #1 chk("s2_fill1_we", 32'(data_we), 'h2);
    @(negedge clk); pmem_resp = 1'b0; mem_read = 1'b0;

    // invalid way 2 chosen even though all ways are dirty: no writeback
    @(negedge clk); set_idx = 3'd3; mem_read = 1'b1;
    way_valid = 4'b1011; way_dirty = 4'b1111; way_hit = 4'b0000;
    @(negedge clk);
    #1;
    chk("inv_victim", 32'(victim_way), 'h2);
    chk("inv_no_wb", 32'(pmem_write), 'h0);
    chk("inv_fill_read", 32'(pmem_read), 'h1);

    // reset while filling
    @(negedge clk); rst_n = 1'b0;
    #1 chk("rst_fill_outs", 32'(outs), 'h0);
    @(negedge clk); rst_n = 1'b1; mem_read = 1'b0;
    #1;
    chk("post_rst_outs", 32'(outs), 'h0);
`ifdef CACHE_PERF_CNT_EN
    chk("post_rst_cnts", 32'(hit_cnt | miss_cnt | wb_cnt), 'h0);
`endif
    @(negedge clk); pmem_resp = 1'b1;
    #1 chk("late_resp_tag_we", 32'(tag_we), 'h0);

    // PLRU cleared by reset: set 2 victim back to 0
    @(negedge clk); pmem_resp = 1'b0; set_idx = 3'd2; mem_read = 1'b1;
    way_valid = 4'b1111; way_dirty = 4'b0000; way_hit = 4'b0000;
    @(negedge clk);
    #1 chk("rst_plru_victim", 32'(victim_way), 'h0);
    @(negedge clk); pmem_resp = 1'b1;
    #1 chk("rst_plru_fill_we", 32'(data_we), 'h1);
    @(negedge clk); pmem_resp = 1'b0; mem_read = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_control_nway.md
Name: cache_control_nway

Overview:
- Parametrised successor to the 2-way write-back cache controller: control FSM for a WAYS-way set-associative, write-back, write-allocate cache.
- Owns the per-set tree-PLRU state and victim selection internally; tag/data/valid/dirty arrays stay in the external datapath.
- Sits between the CPU-side memory port and the physical-memory (pmem) port. Drives all per-way array write enables and the pmem handshake.

Parameters:
- WAYS, 4, associativity; power of 2, 2..16.
- SETS, 8, number of sets; power of 2.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- mem_read, mem_write  in  1 each  CPU request; held stable until mem_resp; never both high.
- set_idx  in  log2(SETS)  set index of the current request.
- way_hit  in  WAYS  per-way tag match AND valid.
- way_valid, way_dirty  in  WAYS each  state of the indexed set.
- pmem_resp  in  1  pmem transaction done; single-cycle pulse.
- mem_resp  out  1  CPU request complete.
- pmem_read, pmem_write  out  1 each  pmem requests; held until pmem_resp.
- pmem_addr_sel  out  1  0 = CPU address, 1 = victim tag + set_idx (writeback).
- victim_way  out  log2(WAYS)  latched victim; selects the writeback data/tag mux.
- data_we, tag_we  out  WAYS each  per-way array writes.
- data_sel  out  1  0 = CPU write data, 1 = pmem fill line.
- valid_set, dirty_set, dirty_clr  out  WAYS each  per-way status updates.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are combinational from state and inputs. The registered state is the FSM state, victim_q, and the PLRU array (SETS x (WAYS-1) bits).
- Reset: state=IDLE, victim_q=0, every PLRU bit=0, counters=0. All outputs are 0 while rst_n is low and in the first IDLE cycle with no request.
- Reset mid-operation: the FSM returns to IDLE on that edge. pmem_read/pmem_write drop the same cycle. No array writes occur.

IDLE:
- Hit (request present and way_hit nonzero): mem_resp=1 in the same cycle, so hit latency is 1 cycle.
- On a hit, the PLRU for set_idx is updated at the clock edge. With multiple hits (an illegal input), the lowest-index way is used.
- Write hit: data_we[h]=1, data_sel=0, dirty_set[h]=1.
- Miss: select the victim and latch it into victim_q.
  - Victim = lowest-index invalid way if any; otherwise the PLRU victim.
  - Next state is WB if way_valid[v] && way_dirty[v], else FILL.
  - No outputs other than busy are asserted on the following cycle until WB/FILL.

WB:
- pmem_write=1, pmem_addr_sel=1, victim_way=victim_q.
- On pmem_resp: dirty_clr[victim_q]=1, then go to FILL.

FILL:
- pmem_read=1, pmem_addr_sel=0.
- On pmem_resp: data_we, tag_we, valid_set and dirty_clr are asserted for victim_q, with data_sel=1. PLRU is updated for victim_q, then go to IDLE.
- The request is re-looked-up in IDLE and hits on the next cycle.
- Miss latency (clean victim) = 1 + fill cycles + 1.

Request withdrawn during WB/FILL (illegal): the transaction still completes; no mem_resp is issued.

PLRU convention:
- Heap-ordered tree, node 0 = root; children of node n are 2n+1 and 2n+2.
- Bit=0 points the victim to the lower half.
- Access to way w sets each node on its path to point away from w.

Optional Feature:
- Macro CACHE_PERF_CNT_EN.
- Defined: adds outputs hit_cnt, miss_cnt, wb_cnt (CNT_W each) and input cnt_clr.
  - hit_cnt increments on each IDLE hit, including the post-fill re-hit.
  - miss_cnt increments on each IDLE miss.
  - wb_cnt increments on each WB pmem_resp.
  - All counters saturate at all-ones.
  - cnt_clr zeroes them synchronously and has priority over an increment in the same cycle.
- Undefined: none of these ports or registers exist; behaviour is otherwise identical.

Test Plan:
- Reset, then a read with way_hit=0010 -> mem_resp=1 the same cycle, no pmem activity, busy=0.
- Write hit way 3 (WAYS=4) -> data_we=1000, dirty_set=1000, data_sel=0, mem_resp=1 in 1 cycle.
- Read miss, all ways valid, PLRU reset (victim 0), way_dirty=0001 -> WB (pmem_write, pmem_addr_sel=1); pmem_resp after 5 cycles -> dirty_clr=0001, FILL; pmem_resp -> data_we/tag_we/valid_set=0001; next cycle hit -> mem_resp.
- PLRU, set 2: after access way 0 -> victim 2; then access way 2 -> victim 1; victim_way is checked on the next miss.
- Miss with way_valid=1011 -> victim 2, goes straight to FILL with no WB.
- rst_n low during FILL with pmem_read high -> next cycle pmem_read=0, busy=0, no tag_we; with CACHE_PERF_CNT_EN, counters read 0.
